// File: rtl/operand_vector_loader_pkg.sv
// Shared definitions for the operand vector loader: clog2 helper, index width and fill FSM states.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package operand_vector_loader_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } fill_state_e;

    // Slot index width; a single-slot vector still needs one bit.
    function automatic int idx_width(input int dim);
        return (dim > 1) ? `CLOG2(dim) : 1;
    endfunction

endpackage

// File: rtl/operand_vector_loader_element_packer.sv
// DIM-slot fill register. merged_o is the buffer including the element written this cycle,
// so a complete vector is available in the same cycle as its final element.
module element_packer #(
    parameter int DIM   = 8,
    parameter int W     = 32,
    parameter int IDX_W = 3
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [W-1:0]     data_i,
    output logic [DIM*W-1:0] merged_o
);

    logic [DIM*W-1:0] fill_q;
    logic [DIM*W-1:0] fill_d;

    always_comb begin
        fill_d = fill_q;
        for (int k = 0; k < DIM; k++) begin
            if (we_i && (idx_i == IDX_W'(k))) begin
                fill_d[k*W +: W] = data_i;
            end
        end
    end

    // Every slot is rewritten before a vector is handed off, so no reset is needed here.
    always_ff @(posedge clk_i) begin
        fill_q <= fill_d;
    end

    assign merged_o = fill_d;

endmodule

// File: rtl/operand_vector_loader.sv
// Packs DIM (a,b) element pairs into vector pairs behind a separate, held output buffer.
// Define OPERAND_VECTOR_LOADER_LAST_CHECK_EN to add in_last_i and a sticky error_o.
module operand_vector_loader
    import operand_vector_loader_pkg::*;
#(
    parameter int DIM          = 8,
    parameter int A_DATA_WIDTH = 32,
    parameter int B_DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [A_DATA_WIDTH-1:0]   in_a_i,
    input  logic [B_DATA_WIDTH-1:0]   in_b_i,
`ifdef OPERAND_VECTOR_LOADER_LAST_CHECK_EN
    input  logic                      in_last_i,
    output logic                      error_o,
`endif
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DIM*A_DATA_WIDTH-1:0] a_o,
    output logic [DIM*B_DATA_WIDTH-1:0] b_o
);

    localparam int IDX_W = idx_width(DIM);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);

    fill_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic out_valid_q, out_valid_d;
    logic [DIM*A_DATA_WIDTH-1:0] a_q, a_d, a_merged;
    logic [DIM*B_DATA_WIDTH-1:0] b_q, b_d, b_merged;
    logic accept, last_pair, full_accept, out_free, transfer;

    assign accept      = in_valid_i && in_ready_o;
    assign last_pair   = (idx_q == IDX_LAST);
    assign full_accept = accept && last_pair;
    assign out_free    = !out_valid_q || out_ready_i;
    // A waiting vector moves as soon as the output slot frees; the final pair comes straight from the inputs.
    assign transfer    = (full_accept && out_free) || ((state_q == STALL) && out_ready_i);

    element_packer #(.DIM(DIM), .W(A_DATA_WIDTH), .IDX_W(IDX_W)) u_pack_a (
        .clk_i    (clk_i),
        .we_i     (accept),
        .idx_i    (idx_q),
        .data_i   (in_a_i),
        .merged_o (a_merged)
    );

    element_packer #(.DIM(DIM), .W(B_DATA_WIDTH), .IDX_W(IDX_W)) u_pack_b (
        .clk_i    (clk_i),
        .we_i     (accept),
        .idx_i    (idx_q),
        .data_i   (in_b_i),
        .merged_o (b_merged)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (full_accept && !out_free) state_d = STALL;
            STALL:   if (out_ready_i) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready_o = (state_q == FILL);
    end

    always_comb begin
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        if (accept) begin
            idx_d = last_pair ? '0 : idx_q + 1'b1;
        end
        if (transfer) begin
            out_valid_d = 1'b1;
            a_d         = a_merged;
            b_d         = b_merged;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign a_o         = a_q;
    assign b_o         = b_q;

`ifdef OPERAND_VECTOR_LOADER_LAST_CHECK_EN
    logic error_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            error_q <= 1'b0;
        end else if (accept && (in_last_i != last_pair)) begin
            error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`endif

endmodule

// File: tb/tb_operand_vector_loader.sv
// Directed bench for operand_vector_loader: queue-based reference model checked every cycle,
// plus literal expectations for each scenario and small DIM=1 / DIM=3 instances.
module tb_operand_vector_loader;

    localparam int DIM = 8;
    localparam int AW  = 32;
    localparam int BW  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic in_valid, out_ready;
    logic [AW-1:0] in_a;
    logic [BW-1:0] in_b;
    logic in_ready, out_valid;
    logic [DIM*AW-1:0] a;
    logic [DIM*BW-1:0] b;
`ifdef OPERAND_VECTOR_LOADER_LAST_CHECK_EN
    logic in_last, err, last1, err1, last3, err3;
`endif

    operand_vector_loader #(.DIM(DIM), .A_DATA_WIDTH(AW), .B_DATA_WIDTH(BW)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b),
`ifdef OPERAND_VECTOR_LOADER_LAST_CHECK_EN
        .in_last_i(in_last), .error_o(err),
`endif
        .out_valid_o(out_valid), .out_ready_i(out_ready), .a_o(a), .b_o(b)
    );

    logic iv1, rdy1, ov1, or1;
    logic [AW-1:0] ia1, a1;
    logic [BW-1:0] ib1, b1;
    operand_vector_loader #(.DIM(1), .A_DATA_WIDTH(AW), .B_DATA_WIDTH(BW)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv1), .in_ready_o(rdy1),
        .in_a_i(ia1), .in_b_i(ib1),
`ifdef OPERAND_VECTOR_LOADER_LAST_CHECK_EN
        .in_last_i(last1), .error_o(err1),
`endif
        .out_valid_o(ov1), .out_ready_i(or1), .a_o(a1), .b_o(b1)
    );

    logic iv3, rdy3, ov3, or3;
    logic [AW-1:0] ia3;
    logic [BW-1:0] ib3;
    logic [3*AW-1:0] a3;
    logic [3*BW-1:0] b3;
    operand_vector_loader #(.DIM(3), .A_DATA_WIDTH(AW), .B_DATA_WIDTH(BW)) dut3 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv3), .in_ready_o(rdy3),
        .in_a_i(ia3), .in_b_i(ib3),
`ifdef OPERAND_VECTOR_LOADER_LAST_CHECK_EN
        .in_last_i(last3), .error_o(err3),
`endif
        .out_valid_o(ov3), .out_ready_i(or3), .a_o(a3), .b_o(b3)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a list of accepted pairs, one pending complete vector, one output slot.
    logic [AW-1:0] mq_a[$];
    logic [BW-1:0] mq_b[$];
    bit m_pending, m_ov, m_err, m_consumed;
    logic [DIM*AW-1:0] m_a;
    logic [DIM*BW-1:0] m_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq_a.delete(); mq_b.delete();
            m_pending = 0; m_ov = 0; m_err = 0;
            m_a = '0; m_b = '0;
        end else begin
            m_consumed = m_ov && out_ready;
            if (!m_pending && in_valid) begin
`ifdef OPERAND_VECTOR_LOADER_LAST_CHECK_EN
                if (in_last != (mq_a.size() == DIM - 1)) m_err = 1;
`endif
                mq_a.push_back(in_a);
                mq_b.push_back(in_b);
            end
            if (mq_a.size() == DIM) m_pending = 1;
            if (m_pending && (!m_ov || m_consumed)) begin
                for (int k = 0; k < DIM; k++) begin
                    m_a[k*AW +: AW] = mq_a[k];
                    m_b[k*BW +: BW] = mq_b[k];
                end
                mq_a.delete(); mq_b.delete();
                m_pending = 0;
                m_ov = 1;
            end else if (m_consumed) begin
                m_ov = 0;
            end
        end
    end

    bit chk_en = 0;
    int pulses = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 256'(out_valid), 256'(m_ov));
            check("in_ready", 256'(in_ready), 256'(!m_pending));
            check("A", 256'(a), 256'(m_a));
            check("B", 256'(b), 256'(m_b));
`ifdef OPERAND_VECTOR_LOADER_LAST_CHECK_EN
            check("error", 256'(err), 256'(m_err));
`endif
            if (out_valid) pulses++;
        end
    end

    int sent = 0;
    bit inject_last = 0;

    // Called at a falling edge; returns at the falling edge after the pair is accepted.
    task automatic send(input logic [AW-1:0] va, input logic [BW-1:0] vb);
        int t;
        in_valid = 1; in_a = va; in_b = vb;
`ifdef OPERAND_VECTOR_LOADER_LAST_CHECK_EN
        in_last = ((sent % DIM) == DIM - 1) ^ inject_last;
`endif
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
        end
        @(negedge clk);
        sent++;
        in_valid = 0;
    endtask

    logic [DIM*AW-1:0] ea;
    logic [DIM*BW-1:0] eb;

    initial begin
        rst = 1; in_valid = 0; out_ready = 0; in_a = '0; in_b = '0;
        iv1 = 0; or1 = 0; ia1 = '0; ib1 = '0; iv3 = 0; or3 = 0; ia3 = '0; ib3 = '0;
`ifdef OPERAND_VECTOR_LOADER_LAST_CHECK_EN
        in_last = 0; last1 = 1; last3 = 0;
`endif
        #2;
        check("reset_out_valid", 256'(out_valid), 256'(0));
        check("reset_A", 256'(a), 256'(0));
        @(negedge clk);
        rst = 0;
        chk_en = 1;
        #1 check("reset_in_ready", 256'(in_ready), 256'(1));

        // Basic fill with the consumer always ready
        out_ready = 1;
        for (int k = 0; k < DIM; k++) send(AW'(k + 1), BW'(2 * (k + 1)));
        for (int k = 0; k < DIM; k++) begin
            ea[k*AW +: AW] = AW'(k + 1);
            eb[k*BW +: BW] = BW'(2 * k + 2);
        end
        check("t1_valid", 256'(out_valid), 256'(1));
        check("t1_A", 256'(a), 256'(ea));
        check("t1_B", 256'(b), 256'(eb));
        @(negedge clk);
        check("t1_valid_drop", 256'(out_valid), 256'(0));

        // Back-to-back vectors
        pulses = 0;
        for (int v = 0; v < 3; v++)
            for (int k = 0; k < DIM; k++) send(AW'(100 * v + k), BW'(32'hA000 + 100 * v + k));
        repeat (2) @(negedge clk);
        check("t2_pulses", 256'(pulses), 256'(3));

        // Backpressure into STALL
        out_ready = 0;
        for (int i = 0; i < 2 * DIM; i++) send(AW'(1000 + i), BW'(5000 + i));
        check("t3_in_ready_stall", 256'(in_ready), 256'(0));
        check("t3_A_holds_v1", 256'(a[AW-1:0]), 256'(1000));
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check("t3_valid_kept", 256'(out_valid), 256'(1));
        check("t3_A_v2", 256'(a[AW-1:0]), 256'(1008));
        check("t3_in_ready_back", 256'(in_ready), 256'(1));
        out_ready = 1;
        @(negedge clk);
        check("t3_drained", 256'(out_valid), 256'(0));

        // Consume and transfer on the same edge
        out_ready = 0;
        for (int i = 0; i < 2 * DIM - 1; i++) send(AW'(2000 + i), BW'(6000 + i));
        out_ready = 1;
        send(AW'(2015), BW'(6015));
        out_ready = 0;
        check("t4_no_bubble", 256'(out_valid), 256'(1));
        check("t4_A_slot0", 256'(a[AW-1:0]), 256'(2008));
        check("t4_A_slot7", 256'(a[7*AW +: AW]), 256'(2015));

        // Asynchronous reset in the middle of a fill
        for (int i = 0; i < 5; i++) send(AW'(7000 + i), BW'(8000 + i));
        #2 rst = 1;
        #1;
        check("t5_valid_async", 256'(out_valid), 256'(0));
        check("t5_A_async", 256'(a), 256'(0));
        check("t5_B_async", 256'(b), 256'(0));
        @(negedge clk);
        rst = 0;
        sent = 0;
        out_ready = 1;
        pulses = 0;
        for (int k = 0; k < DIM; k++) send(AW'(3000 + k), BW'(4000 + k));
        for (int k = 0; k < DIM; k++) ea[k*AW +: AW] = AW'(3000 + k);
        check("t5_A_post_reset", 256'(a), 256'(ea));
        repeat (3) @(negedge clk);
        check("t5_one_vector", 256'(pulses), 256'(1));

`ifdef OPERAND_VECTOR_LOADER_LAST_CHECK_EN
        // Misplaced last marker on pair 6 of 8
        check("t6_err_clear", 256'(err), 256'(0));
        for (int k = 0; k < DIM; k++) begin
            inject_last = (k == 5);
            send(AW'(9000 + k), BW'(9500 + k));
            inject_last = 0;
            if (k == 5) check("t6_err_set", 256'(err), 256'(1));
        end
        check("t6_A_unaffected", 256'(a[5*AW +: AW]), 256'(9005));
        @(negedge clk);
        check("t6_err_sticky", 256'(err), 256'(1));
        rst = 1;
        #1 check("t6_err_reset", 256'(err), 256'(0));
        @(negedge clk);
        rst = 0;
        sent = 0;
`endif

        // DIM=1: every accept completes a vector
        iv1 = 1; or1 = 1; ia1 = 7; ib1 = 14;
        @(negedge clk);
        check("d1_valid", 256'(ov1), 256'(1));
        check("d1_A", 256'(a1), 256'(7));
        check("d1_B", 256'(b1), 256'(14));
        ia1 = 9; ib1 = 18;
        @(negedge clk);
        check("d1_A_next", 256'(a1), 256'(9));
        check("d1_valid_next", 256'(ov1), 256'(1));
        iv1 = 0;
        @(negedge clk);
        check("d1_idle", 256'(ov1), 256'(0));

        // DIM=3 basic fill
        iv3 = 1; or3 = 1;
        for (int k = 0; k < 3; k++) begin
            ia3 = AW'(k + 1); ib3 = BW'(2 * k + 2);
`ifdef OPERAND_VECTOR_LOADER_LAST_CHECK_EN
            last3 = (k == 2);
`endif
            @(negedge clk);
            if (k < 2) check("d3_not_yet", 256'(ov3), 256'(0));
        end
        iv3 = 0;
        check("d3_valid", 256'(ov3), 256'(1));
        check("d3_A", 256'(a3), {160'd0, 32'd3, 32'd2, 32'd1});
        check("d3_B", 256'(b3), {160'd0, 32'd6, 32'd4, 32'd2});

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
